// File: rtl/ll_receive_credit_fifo_pkg.sv
// ll_rx_pkg: shared helpers and debug-status field layout for the receive credit FIFO.
package ll_rx_pkg;
  localparam int DBG_COUNT_LSB = 0;
  localparam int DBG_PEND_LSB  = 8;
  localparam int DBG_OVF_BIT   = 31;

  function automatic logic [3:0] thermo4(int n);
    return (n >= 4) ? 4'hf : (n <= 0) ? 4'h0 : 4'((32'd1 << n) - 32'd1);
  endfunction
endpackage

// File: rtl/ll_receive_credit_fifo_if.sv
// ll_receive_credit_fifo_if: receive-word, user-stream and credit-return signals of the link receiver.
interface ll_receive_credit_fifo_if #(
  parameter int WIDTH = 256
);
  logic             rx_i_pushbit;
  logic [WIDTH-1:0] rx_i_data;
  logic             user_i_valid;
  logic [WIDTH-1:0] user_i_data;
  logic             user_i_ready;
  logic [3:0]       tx_i_credit;

  modport master (
    output rx_i_pushbit, rx_i_data, user_i_ready,
    input  user_i_valid, user_i_data, tx_i_credit
  );
  modport slave (
    input  rx_i_pushbit, rx_i_data, user_i_ready,
    output user_i_valid, user_i_data, tx_i_credit
  );
endinterface

// File: rtl/ll_receive_credit_fifo_buf.sv
// ll_rx_buf: show-ahead pointer FIFO; a push while full is accepted only alongside a pop.
module ll_rx_buf #(
  parameter int WIDTH = 256,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk_wr,
  input  logic             rst_wr_n,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic [AW:0]      o_count,
  output logic             o_empty,
  output logic             o_wr
);
  localparam logic [AW:0] ONE = 1;
  logic [AW:0]      r_wr_ptr, r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_rd, w_wr;

  assign o_count = r_wr_ptr - r_rd_ptr;
  assign o_empty = r_wr_ptr == r_rd_ptr;
  assign w_rd    = i_pop & ~o_empty;
  // count never exceeds DEPTH, so its top bit alone flags full
  assign w_wr    = i_push & ~i_flush & (~o_count[AW] | w_rd);
  assign o_wr    = w_wr;
  assign o_data  = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + ONE;
      if (w_rd) r_rd_ptr <= r_rd_ptr + ONE;
    end
  end

  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_wr) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end
  end
endmodule

// File: rtl/ll_receive_credit_fifo.sv
// ll_receive_credit_fifo: receive buffer for a streaming logic link that returns
// one credit to the far-end transmitter per freed entry.
module ll_receive_credit_fifo
  import ll_rx_pkg::*;
#(
  parameter int WIDTH        = 256,
  parameter int DEPTH        = 8,
  parameter int TX_CRED_SIZE = 1
) (
  input  logic                    clk_wr,
  input  logic                    rst_wr_n,
  input  logic                    tx_online,
  input  logic                    rx_online,
  ll_receive_credit_fifo_if.slave bus,
  output logic [31:0]             rx_i_debug_status
);
  localparam int AW = $clog2(DEPTH);
  // returned credits can never exceed DEPTH, so the cap fits the pending width
  localparam int CM = (TX_CRED_SIZE < DEPTH) ? TX_CRED_SIZE : DEPTH;
  localparam logic [AW:0] CRED_MAX = CM[AW:0];

  logic [AW:0] w_count, w_avail, w_ret, r_pending;
  logic [3:0]  r_credit;
  logic        w_empty, w_wr, w_pop, w_ovf_evt, r_ovf;

  ll_rx_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_buf (
    .clk_wr  (clk_wr),
    .rst_wr_n(rst_wr_n),
    .i_flush (~rx_online),
    .i_push  (bus.rx_i_pushbit),
    .i_pop   (bus.user_i_ready),
    .i_data  (bus.rx_i_data),
    .o_data  (bus.user_i_data),
    .o_count (w_count),
    .o_empty (w_empty),
    .o_wr    (w_wr)
  );

  assign bus.user_i_valid = ~w_empty;
  assign bus.tx_i_credit  = r_credit;
  assign w_pop     = bus.user_i_ready & ~w_empty;
  assign w_ovf_evt = bus.rx_i_pushbit & rx_online & ~w_wr;
  assign w_avail   = r_pending + {{AW{1'b0}}, w_pop};
  assign w_ret     = ~tx_online ? '0 : (w_avail > CRED_MAX) ? CRED_MAX : w_avail;

  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      r_pending <= '0;
      r_credit  <= '0;
      r_ovf     <= 1'b0;
    end else begin
      r_ovf     <= r_ovf | w_ovf_evt;
      r_pending <= rx_online ? w_avail - w_ret : '0;
      r_credit  <= rx_online ? thermo4(int'(w_ret)) : 4'h0;
    end
  end

  always_comb begin
    rx_i_debug_status = '0;
    rx_i_debug_status[DBG_OVF_BIT] = r_ovf;
    rx_i_debug_status[DBG_PEND_LSB +: 8] = 8'(r_pending);
    rx_i_debug_status[DBG_COUNT_LSB +: 8] = 8'(w_count);
  end
endmodule

// File: tb/tb_ll_receive_credit_fifo.sv
// tb_ll_receive_credit_fifo: vector table, directed corner sequences and random traffic
// checked against a queue-based model of the receive buffer and credit return.
module tb_ll_receive_credit_fifo;
  localparam int W = 32, D = 8, TCS = 2;

  logic        clk = 0, rst_n = 1, tx_online = 0, rx_online = 0;
  logic [31:0] dbg;
  int          checks = 0, errors = 0;
  logic [W-1:0] q[$];
  int          m_pend = 0, m_cred = 0;
  bit          m_ovf = 0;

  ll_receive_credit_fifo_if #(.WIDTH(W)) bus ();

  ll_receive_credit_fifo #(.WIDTH(W), .DEPTH(D), .TX_CRED_SIZE(TCS)) dut (
    .clk_wr           (clk),
    .rst_wr_n         (rst_n),
    .tx_online        (tx_online),
    .rx_online        (rx_online),
    .bus              (bus),
    .rx_i_debug_status(dbg)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         push;
    logic [W-1:0] data;
    bit         rdy;
    bit         e_valid;
    logic [W-1:0] e_data;
    int         e_count;
    int         e_cred;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("valid", 32'(bus.user_i_valid), q.size() != 0);
    if (q.size() != 0) chk("data", bus.user_i_data, q[0]);
    chk("credit", 32'(bus.tx_i_credit), m_cred);
    chk("count", 32'(dbg[7:0]), q.size());
    chk("pending", 32'(dbg[15:8]), m_pend);
    chk("ovf", 32'(dbg[31]), 32'(m_ovf));
    chk("dbg_zero", 32'(dbg[30:16]), 0);
  endtask

  // one clock: drive inputs, step the model by the link rules, compare all outputs
  task automatic cyc(input bit push, input logic [W-1:0] d, input bit rdy, input bit txon, input bit rxon);
    int pop, avail, ret;
    bit acc;
    bus.rx_i_pushbit = push; bus.rx_i_data = d; bus.user_i_ready = rdy;
    tx_online = txon; rx_online = rxon;
    pop   = (rdy && q.size() != 0) ? 1 : 0;
    acc   = push && rxon && (q.size() - pop < D);
    avail = m_pend + pop;
    ret   = txon ? ((avail < TCS) ? avail : TCS) : 0;
    @(posedge clk); #1;
    if (push && rxon && !acc) m_ovf = 1;
    if (!rxon) begin
      q.delete(); m_pend = 0; m_cred = 0;
    end else begin
      if (pop != 0) void'(q.pop_front());
      if (acc) q.push_back(d);
      m_pend = avail - ret;
      m_cred = (1 << ret) - 1;
    end
    check_model();
  endtask

  task automatic idle_inputs();
    bus.rx_i_pushbit = 0; bus.rx_i_data = '0; bus.user_i_ready = 0;
  endtask

  initial begin
    logic [W-1:0] w[9];
    int exp_cred[4];
    idle_inputs();
    tbl[0] = '{1, 32'hAAAA_0001, 0, 1, 32'hAAAA_0001, 1, 0};
    tbl[1] = '{1, 32'hBBBB_0002, 0, 1, 32'hAAAA_0001, 2, 0};
    tbl[2] = '{1, 32'hCCCC_0003, 0, 1, 32'hAAAA_0001, 3, 0};
    tbl[3] = '{0, 32'h0,         1, 1, 32'hBBBB_0002, 2, 1};
    tbl[4] = '{0, 32'h0,         1, 1, 32'hCCCC_0003, 1, 1};
    tbl[5] = '{0, 32'h0,         1, 0, 32'h0,         0, 1};
    tbl[6] = '{0, 32'h0,         0, 0, 32'h0,         0, 0};

    #1 rst_n = 0;
    #2;
    chk("rst_valid", 32'(bus.user_i_valid), 0);
    chk("rst_data", bus.user_i_data, 0);
    chk("rst_credit", 32'(bus.tx_i_credit), 0);
    chk("rst_dbg", dbg, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) begin
      cyc(tbl[i].push, tbl[i].data, tbl[i].rdy, 1, 1);
      chk("tbl_valid", 32'(bus.user_i_valid), 32'(tbl[i].e_valid));
      if (tbl[i].e_valid) chk("tbl_data", bus.user_i_data, tbl[i].e_data);
      chk("tbl_count", 32'(dbg[7:0]), tbl[i].e_count);
      chk("tbl_credit", 32'(bus.tx_i_credit), tbl[i].e_cred);
    end

    for (int i = 0; i < 8; i++) begin
      w[i] = 32'hF000_0000 + i;
      cyc(1, w[i], 0, 1, 1);
    end
    cyc(1, 32'hDEAD_BEEF, 0, 1, 1);
    chk("ovf_set", 32'(dbg[31]), 1);
    chk("ovf_count", 32'(dbg[7:0]), 8);
    w[8] = 32'h1234_5678;
    for (int i = 0; i < 9; i++) begin
      chk("fill_order", bus.user_i_data, w[i]);
      cyc(i == 0, w[8], 1, 1, 1);
      chk("fill_credit", 32'(bus.tx_i_credit), 1);
    end
    cyc(0, 0, 0, 1, 1);
    chk("fill_idle_credit", 32'(bus.tx_i_credit), 0);

    for (int i = 0; i < 5; i++) cyc(1, $urandom, 0, 1, 1);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0, 1);
    chk("txoff_pending", 32'(dbg[15:8]), 5);
    chk("txoff_credit", 32'(bus.tx_i_credit), 0);
    exp_cred = '{3, 3, 1, 0};
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 1, 1);
      chk("release_credit", 32'(bus.tx_i_credit), exp_cred[i]);
    end

    for (int i = 0; i < 4; i++) cyc(1, $urandom, 0, 1, 1);
    for (int i = 0; i < 100; i++) begin
      cyc(1, $urandom, 1, 1, 1);
      chk("thru_count", 32'(dbg[7:0]), 4);
      chk("thru_credit", 32'(bus.tx_i_credit), 1);
    end

    cyc(1, $urandom, 0, 1, 1);
    cyc(1, $urandom, 0, 1, 1);
    cyc(0, 0, 1, 0, 1);
    cyc(0, 0, 1, 0, 1);
    chk("pre_flush_count", 32'(dbg[7:0]), 4);
    chk("pre_flush_pending", 32'(dbg[15:8]), 2);
    cyc(1, $urandom, 1, 1, 0);
    chk("flush_valid", 32'(bus.user_i_valid), 0);
    chk("flush_count", 32'(dbg[7:0]), 0);
    chk("flush_pending", 32'(dbg[15:8]), 0);
    chk("flush_credit", 32'(bus.tx_i_credit), 0);
    chk("flush_ovf_kept", 32'(dbg[31]), 1);

    for (int i = 0; i < 300; i++)
      cyc($urandom_range(3) != 0, $urandom, $urandom_range(1) == 1,
          $urandom_range(3) != 0, $urandom_range(15) != 0);

    cyc(1, $urandom, 0, 1, 1);
    cyc(1, $urandom, 1, 1, 1);
    idle_inputs();
    #2 rst_n = 0;
    #1;
    chk("async_rst_valid", 32'(bus.user_i_valid), 0);
    chk("async_rst_data", bus.user_i_data, 0);
    chk("async_rst_credit", 32'(bus.tx_i_credit), 0);
    chk("async_rst_dbg", dbg, 0);
    q.delete(); m_pend = 0; m_cred = 0; m_ovf = 0;
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    cyc(0, 0, 1, 1, 1);
    chk("post_rst_no_credit", 32'(bus.tx_i_credit), 0);
    cyc(1, 32'h5555_AAAA, 0, 1, 1);
    cyc(0, 0, 1, 1, 1);
    chk("post_rst_credit", 32'(bus.tx_i_credit), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
